// File: rtl/arb_mux_nto1.sv
// -----------------------------------------------------------------------------
// arb_mux_nto1
//
// N-to-1 arbitrating multiplexer with a single registered output word.
// A channel is chosen either directly by `sel` (MODE=0) or by a round-robin
// scan that starts at the channel after the last one served (MODE=1). The
// chosen word is captured into the output register whenever that register is
// empty or being drained in the same cycle, so a continuously-ready consumer
// receives one word per clock with one cycle of latency.
//
// Parameters
//   WIDTH : data bits per channel (>= 1)
//   N     : number of input channels (>= 2)
//   MODE  : 0 = select-driven, 1 = round-robin
//   SW    : width of sel / out_chan / round-robin pointer
//
// Ports
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   in_data   : N packed channels, channel i at [i*WIDTH +: WIDTH]
//   in_valid  : per-channel valid
//   in_ready  : per-channel take strobe (one-hot or zero, combinational)
//   sel       : channel select, MODE=0 only
//   out_data  : registered selected word
//   out_valid : out_data holds a word not yet taken downstream
//   out_ready : downstream takes out_data this cycle
//   out_chan  : channel index that supplied out_data
// -----------------------------------------------------------------------------
module arb_mux_nto1 #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int MODE  = 1,
  parameter int SW    = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SW-1:0]      sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SW-1:0]      out_chan
);

  logic [WIDTH-1:0] data_q;
  logic [SW-1:0]    chan_q;
  logic             valid_q;
  logic [SW-1:0]    ptr_q;
  logic [SW-1:0]    ptr_d;

  logic [SW-1:0]    grant;
  logic             grant_valid;
  logic [WIDTH-1:0] grant_data;
  logic             load_en;

  // Round-robin search state: distance (upward, wrapping) of a candidate
  // channel from ptr_q. The valid channel with the smallest distance wins.
  int               rr_off;
  int               rr_best;

  // ---------------------------------------------------------------------------
  // Grant selection
  // ---------------------------------------------------------------------------
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    rr_off      = 0;
    rr_best     = N;
    if (MODE == 0) begin
      grant = sel;
      // Only an in-range sel can match a channel; anything else gives no grant.
      for (int i = 0; i < N; i++) begin
        if (sel == SW'(i)) grant_valid = in_valid[i];
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (in_valid[i]) begin
          rr_off = (i >= int'(ptr_q)) ? (i - int'(ptr_q)) : (i + N - int'(ptr_q));
          if (rr_off < rr_best) begin
            rr_best = rr_off;
            grant   = SW'(i);
          end
        end
      end
      grant_valid = |in_valid;
    end
  end

  // Data mux over constant indices so an out-of-range grant simply selects
  // nothing rather than slicing past the end of in_data.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SW'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // The output register accepts a new word when it is empty or being drained
  // this cycle. Gating with rst keeps in_ready quiet for the whole reset.
  assign load_en = !rst && (!valid_q || out_ready) && grant_valid;

  // in_ready only ever asserts for the granted channel, and the grant is only
  // valid for a channel whose in_valid is high.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = load_en && (grant == SW'(i));
    end
  end

  // Pointer advances to the channel after the one just served; fixed at 0 in
  // select-driven mode.
  always_comb begin
    ptr_d = ptr_q;
    if (MODE == 0) begin
      ptr_d = '0;
    end else if (load_en) begin
      ptr_d = (grant == SW'(N-1)) ? '0 : grant + SW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Output register stage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (load_en) begin
        data_q  <= grant_data;
        chan_q  <= grant;
        valid_q <= 1'b1;
      end else if (out_ready) begin
        // Drained with nothing to replace it: data and channel keep their values.
        valid_q <= 1'b0;
      end
    end
  end

  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign out_valid = valid_q;

endmodule
